// File: rtl/const_lut_pkg.sv
// -----------------------------------------------------------------------------
// const_lut_pkg
// Shared definitions for the constant-LUT sharing logic.
//   LUT_IDX_W / LUT_DATA_W : geometry of the combinational constant LUT
//   MAX_REQ                : widest requester vector the picker function handles
//   lut_idx_t / lut_data_t : LUT index and data types
//   onehot_rr()            : round-robin one-hot grant over up to MAX_REQ requests
// -----------------------------------------------------------------------------
package const_lut_pkg;

  localparam int unsigned LUT_IDX_W  = 3;
  localparam int unsigned LUT_DATA_W = 8;
  localparam int unsigned MAX_REQ    = 4;

  typedef logic [LUT_IDX_W-1:0]  lut_idx_t;
  typedef logic [LUT_DATA_W-1:0] lut_data_t;

  // Searches from last+1 upward, wrapping modulo num_req, and returns the
  // first set request as a one-hot vector. Bits at or above num_req must be
  // zero in req; they are never selected.
  function automatic logic [MAX_REQ-1:0] onehot_rr(input logic [MAX_REQ-1:0] req,
                                                   input logic [1:0]         last,
                                                   input int unsigned        num_req);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [1:0]         pos;
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req) begin
        pos = 2'((32'(last) + k) % num_req);
        if (!found && req[pos]) begin
          gnt[pos] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/const_lut_arbiter_if.sv
// -----------------------------------------------------------------------------
// const_lut_arbiter_if
// Bundles the requester, LUT and response signals of const_lut_arbiter.
//   arb_en       : 1 = grants allowed, 0 = arbitration frozen
//   req_valid    : per-requester lookup request
//   req_idx      : packed indices, requester i at [i*IDX_W +: IDX_W]
//   req_ready    : one-hot combinational grant
//   lut_idx      : index presented to the external LUT
//   lut_data     : LUT output for lut_idx, same cycle
//   rsp_valid    : one-hot registered response strobe
//   rsp_data     : registered LUT value
//   rsp_idx      : registered echo of the granted index
//   conflict_cnt : saturating count of contended cycles
// Modports: slave = arbiter side, master = requesters + LUT side.
// -----------------------------------------------------------------------------
interface const_lut_arbiter_if
  import const_lut_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = LUT_IDX_W,
  parameter int unsigned DATA_W  = LUT_DATA_W,
  parameter int unsigned CNT_W   = 8
);

  logic                     arb_en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_idx;
  logic [NUM_REQ-1:0]       req_ready;
  logic [IDX_W-1:0]         lut_idx;
  logic [DATA_W-1:0]        lut_data;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic [IDX_W-1:0]         rsp_idx;
  logic [CNT_W-1:0]         conflict_cnt;

  modport slave (
    input  arb_en, req_valid, req_idx, lut_data,
    output req_ready, lut_idx, rsp_valid, rsp_data, rsp_idx, conflict_cnt
  );

  modport master (
    output arb_en, req_valid, req_idx, lut_data,
    input  req_ready, lut_idx, rsp_valid, rsp_data, rsp_idx, conflict_cnt
  );

endinterface

// File: rtl/const_lut_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin picker, reusable by any shared-resource arbiter.
//   i_req  : request vector (NUM_REQ bits)
//   i_last : index of the most recently granted requester
//   i_en   : 0 forces the grant to all zeros
//   o_gnt  : one-hot grant, the first request after i_last (wrapping)
// -----------------------------------------------------------------------------
module rr_grant
  import const_lut_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_last,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [MAX_REQ-1:0] w_fullGnt;

  // The package function works on a fixed MAX_REQ-wide vector; the padded
  // upper request bits are zero, so only the low NUM_REQ grant bits can set.
  assign w_fullGnt = onehot_rr(MAX_REQ'(i_req), 2'(i_last), NUM_REQ);
  assign o_gnt     = i_en ? NUM_REQ'(w_fullGnt) : '0;

endmodule

// File: rtl/const_lut_arbiter.sv
// -----------------------------------------------------------------------------
// const_lut_arbiter
// Shares one combinational constant LUT between NUM_REQ requesters with fair
// round-robin arbitration, one lookup per cycle and a registered response one
// cycle after the grant.
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : const_lut_arbiter_if.slave (requests, LUT port, responses, counter)
// -----------------------------------------------------------------------------
module const_lut_arbiter
  import const_lut_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = LUT_IDX_W,
  parameter int unsigned DATA_W  = LUT_DATA_W,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  const_lut_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_lastGrant;
  logic [NUM_REQ-1:0] r_rspValid;
  logic [DATA_W-1:0]  r_rspData;
  logic [IDX_W-1:0]   r_rspIdx;
  logic [CNT_W-1:0]   r_conflictCnt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_gntIdx;
  logic [IDX_W-1:0]   w_lutIdx;
  logic               w_anyGnt;
  logic               w_conflict;

  rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_rrGrant (
    .i_req  (bus.req_valid),
    .i_last (r_lastGrant),
    .i_en   (bus.arb_en),
    .o_gnt  (w_gnt)
  );

  // Turn the one-hot grant into an index and steer the winner's LUT index;
  // with no grant the LUT sees index 0.
  always_comb begin
    w_gntIdx = '0;
    w_lutIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gntIdx = PTR_W'(i);
        w_lutIdx = bus.req_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  assign w_anyGnt   = |w_gnt;
  assign w_conflict = bus.arb_en && ($countones(bus.req_valid) >= 2);

  assign bus.req_ready    = w_gnt;
  assign bus.lut_idx      = w_lutIdx;
  assign bus.rsp_valid    = r_rspValid;
  assign bus.rsp_data     = r_rspData;
  assign bus.rsp_idx      = r_rspIdx;
  assign bus.conflict_cnt = r_conflictCnt;

  // Response and pointer registers. The pointer resets to the last requester
  // so requester 0 wins first. Data and index hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= PTR_W'(NUM_REQ - 1);
      r_rspValid  <= '0;
      r_rspData   <= '0;
      r_rspIdx    <= '0;
    end else if (w_anyGnt) begin
      r_lastGrant <= w_gntIdx;
      r_rspValid  <= w_gnt;
      r_rspData   <= bus.lut_data;
      r_rspIdx    <= w_lutIdx;
    end else begin
      r_rspValid  <= '0;
    end
  end

  // Saturating count of contended cycles; stops at all-ones, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflictCnt <= '0;
    end else if (w_conflict && (r_conflictCnt != '1)) begin
      r_conflictCnt <= r_conflictCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_const_lut_arbiter.sv
// -----------------------------------------------------------------------------
// tb_const_lut_arbiter
// Self-checking bench for const_lut_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle against
// a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_const_lut_arbiter;
  import const_lut_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  lut_data_t lutTable [8] = '{8'h1f, 8'd8, 8'd25, 8'hff, 8'h42, 8'd65, 8'h99, 8'h3c};

  logic [NUM_REQ-1:0] expReadySeq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  lut_data_t          expDataSeq  [3] = '{8'hff, 8'd65, 8'hff};

  // Model state: what the arbiter must remember between cycles
  int        mLast     = NUM_REQ - 1;
  logic [1:0] mRspValid = '0;
  lut_data_t mRspData  = '0;
  lut_idx_t  mRspIdx   = '0;
  int        mCnt      = 0;

  const_lut_arbiter_if #(
    .NUM_REQ (NUM_REQ), .IDX_W (IDX_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
  ) bus ();

  const_lut_arbiter #(
    .NUM_REQ (NUM_REQ), .IDX_W (IDX_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // The shared constant LUT lives outside the arbiter
  assign bus.lut_data = lutTable[bus.lut_idx];

  function automatic lut_idx_t idxOf(input int r);
    return bus.req_idx[r*IDX_W +: IDX_W];
  endfunction

  // Who wins this cycle: walk the requesters in order starting just after the
  // previous winner, take the first one asking; nobody wins when disabled.
  function automatic int pickWinner(input logic [NUM_REQ-1:0] valid, input logic en,
                                    input int last);
    int cand;
    if (!en) return -1;
    for (int step = 1; step <= int'(NUM_REQ); step++) begin
      cand = (last + step) % int'(NUM_REQ);
      if (valid[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input lut_idx_t idx0,
                               input lut_idx_t idx1, input logic en);
    bus.req_valid = valid;
    bus.req_idx   = {idx1, idx0};
    bus.arb_en    = en;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(2'b00, 3'd0, 3'd0, 1'b0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  // Advance the model on each rising edge; reset clears it asynchronously.
  always @(posedge clk or negedge rst_n) begin : modelUpdate
    int g;
    if (!rst_n) begin
      mLast     = NUM_REQ - 1;
      mRspValid = '0;
      mRspData  = '0;
      mRspIdx   = '0;
      mCnt      = 0;
    end else begin
      g = pickWinner(bus.req_valid, bus.arb_en, mLast);
      if (g >= 0) begin
        mRspValid    = '0;
        mRspValid[g] = 1'b1;
        mRspIdx      = idxOf(g);
        mRspData     = lutTable[mRspIdx];
        mLast        = g;
      end else begin
        mRspValid = '0;
      end
      if (bus.arb_en && ($countones(bus.req_valid) >= 2) && (mCnt < 255)) mCnt++;
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin : compare
    int g;
    logic [NUM_REQ-1:0] expReady;
    lut_idx_t           expLut;
    g        = pickWinner(bus.req_valid, bus.arb_en, mLast);
    expReady = '0;
    expLut   = '0;
    if (g >= 0) begin
      expReady[g] = 1'b1;
      expLut      = idxOf(g);
    end
    checkOutput("model req_ready",    32'(bus.req_ready),    32'(expReady));
    checkOutput("model lut_idx",      32'(bus.lut_idx),      32'(expLut));
    checkOutput("model rsp_valid",    32'(bus.rsp_valid),    32'(mRspValid));
    checkOutput("model rsp_data",     32'(bus.rsp_data),     32'(mRspData));
    checkOutput("model rsp_idx",      32'(bus.rsp_idx),      32'(mRspIdx));
    checkOutput("model conflict_cnt", 32'(bus.conflict_cnt), 32'(mCnt));
  end

  // Guard against a hung run
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with literal expectations, then random traffic
  initial begin
    applyStimulus(2'b00, 3'd0, 3'd0, 1'b0);

    // Reset values
    @(negedge clk);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_data",  32'(bus.rsp_data),  32'd0);
    checkOutput("reset rsp_idx",   32'(bus.rsp_idx),   32'd0);
    checkOutput("reset cnt",       32'(bus.conflict_cnt), 32'd0);
    nextCycle();
    rst_n = 1'b1;

    // Requester 0 alone, single lookup of idx 1
    applyStimulus(2'b01, 3'd1, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("s1 ready", 32'(bus.req_ready), 32'b01);
    checkOutput("s1 lut_idx", 32'(bus.lut_idx), 32'd1);
    nextCycle();
    applyStimulus(2'b00, 3'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("s1 rsp_valid", 32'(bus.rsp_valid), 32'b01);
    checkOutput("s1 rsp_data",  32'(bus.rsp_data),  32'd8);
    checkOutput("s1 rsp_idx",   32'(bus.rsp_idx),   32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("s1 rsp_valid drop", 32'(bus.rsp_valid), 32'b00);
    nextCycle();

    // Both requesters contend for four cycles from reset
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 3'd3, 3'd5, 1'b1);
      @(negedge clk);
      checkOutput("s2 ready", 32'(bus.req_ready), 32'(expReadySeq[k]));
      if (k > 0) checkOutput("s2 rsp_data", 32'(bus.rsp_data), 32'(expDataSeq[k-1]));
      nextCycle();
    end
    applyStimulus(2'b00, 3'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("s2 last rsp_valid", 32'(bus.rsp_valid), 32'b10);
    checkOutput("s2 last rsp_data",  32'(bus.rsp_data),  32'd65);
    checkOutput("s2 cnt",            32'(bus.conflict_cnt), 32'd4);
    nextCycle();

    // Requester 1 alone, back-to-back
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b10, 3'd0, 3'd0, 1'b1);
      @(negedge clk);
      checkOutput("s3 ready", 32'(bus.req_ready), 32'b10);
      if (k > 0) begin
        checkOutput("s3 rsp_valid", 32'(bus.rsp_valid), 32'b10);
        checkOutput("s3 rsp_data",  32'(bus.rsp_data),  32'h1f);
      end
      nextCycle();
    end

    // Freeze arbitration right after a grant to requester 0
    applyStimulus(2'b01, 3'd2, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("s4 ready", 32'(bus.req_ready), 32'b01);
    nextCycle();
    applyStimulus(2'b11, 3'd2, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("s4 frozen ready", 32'(bus.req_ready), 32'b00);
    checkOutput("s4 rsp_valid",    32'(bus.rsp_valid), 32'b01);
    checkOutput("s4 rsp_data",     32'(bus.rsp_data),  32'd25);
    nextCycle();
    @(negedge clk);
    checkOutput("s4 frozen ready 2", 32'(bus.req_ready), 32'b00);
    checkOutput("s4 rsp_valid gone", 32'(bus.rsp_valid), 32'b00);
    nextCycle();
    applyStimulus(2'b11, 3'd2, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("s4 reenable ready", 32'(bus.req_ready), 32'b10);
    nextCycle();

    // Counter saturation
    applyStimulus(2'b11, 3'd4, 3'd7, 1'b1);
    repeat (300) nextCycle();
    @(negedge clk);
    checkOutput("s5 cnt saturated", 32'(bus.conflict_cnt), 32'd255);
    repeat (5) nextCycle();
    @(negedge clk);
    checkOutput("s5 cnt held", 32'(bus.conflict_cnt), 32'd255);
    nextCycle();

    // Reset pulse in the cycle after a grant
    applyStimulus(2'b01, 3'd4, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("s6 ready", 32'(bus.req_ready), 32'b01);
    nextCycle();
    checkOutput("s6 rsp_valid before reset", 32'(bus.rsp_valid), 32'b01);
    rst_n = 1'b0;
    #1;
    checkOutput("s6 rsp_valid async drop", 32'(bus.rsp_valid), 32'b00);
    #1;
    rst_n = 1'b1;
    applyStimulus(2'b11, 3'd6, 3'd7, 1'b1);
    @(negedge clk);
    checkOutput("s6 no stale rsp", 32'(bus.rsp_valid), 32'b00);
    checkOutput("s6 r0 first",     32'(bus.req_ready), 32'b01);
    nextCycle();
    @(negedge clk);
    checkOutput("s6 rsp_idx",  32'(bus.rsp_idx),  32'd6);
    checkOutput("s6 rsp_data", 32'(bus.rsp_data), 32'h99);
    nextCycle();

    // Randomized traffic, checked by the model every cycle
    repeat (2000) begin
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0));
      nextCycle();
    end
    applyStimulus(2'b00, 3'd0, 3'd0, 1'b0);
    nextCycle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/const_lut_arbiter.md
Name: const_lut_arbiter

Overview:
- Shares the single combinational constant LUT (3-bit index -> 8-bit constant) between NUM_REQ requesters, e.g. the decode-stage immediate path and the address generator.
- Fair round-robin arbitration, one LUT lookup per cycle, registered response one cycle after grant.
- Sits between the requesters and the LUT instance. The LUT stays purely combinational and is instantiated outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDX_W, 3, LUT index width.
- DATA_W, 8, LUT data width.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- arb_en  input  1  1 = grants allowed; 0 = freeze arbitration.
- req_valid  input  NUM_REQ  per-requester lookup request.
- req_idx  input  NUM_REQ*IDX_W  packed indices; requester i uses bits [i*IDX_W +: IDX_W].
- req_ready  output  NUM_REQ  one-hot combinational grant; a handshake occurs when req_valid[i] && req_ready[i].
- lut_idx  output  IDX_W  index driven to the LUT.
- lut_data  input  DATA_W  LUT output for lut_idx, same cycle.
- rsp_valid  output  NUM_REQ  one-hot registered response strobe.
- rsp_data  output  DATA_W  registered LUT value.
- rsp_idx  output  IDX_W  registered echo of the granted index.
- conflict_cnt  output  CNT_W  saturating count of cycles with two or more req_valid bits set while arb_en=1.

Behaviour:
- Reset (async assert, rst_n=0):
  - rsp_valid=0, rsp_data=0, rsp_idx=0, conflict_cnt=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- req_ready is combinational from req_valid, arb_en and last_grant:
  - All zero when arb_en=0 or no req_valid.
  - Otherwise exactly one bit set: the first valid requester searching from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready never asserts for a requester whose req_valid is 0.
- lut_idx = req_idx of the granted requester when a grant exists, else 0.
- On every clock edge with a grant to requester g:
  - rsp_valid <= onehot(g), rsp_data <= lut_data, rsp_idx <= lut_idx, last_grant <= g.
- On an edge with no grant: rsp_valid <= 0. rsp_data and rsp_idx hold. last_grant holds.
- Latency is exactly 1 cycle from handshake to rsp_valid. Throughput is one lookup per cycle.
- rsp_valid is a single-cycle pulse with no backpressure; requesters must accept it.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles while arb_en=1.
- Back-to-back requests from one lone requester are granted every cycle.
- Requests are not latched internally. A requester must hold req_valid and req_idx stable until it sees req_ready.
  - A requester that drops req_valid before grant simply loses its request. This is not an error.
- arb_en=0:
  - No grants; last_grant frozen.
  - A response registered on the previous edge still appears (rsp_valid high for one cycle).
  - conflict_cnt does not count.
- conflict_cnt increments by 1 on each edge where popcount(req_valid) >= 2 and arb_en=1. It saturates at all-ones and never wraps.
- Reset mid-operation: any pending rsp_valid is dropped immediately (async). No response is produced after rst_n deasserts for a pre-reset grant.
- Requester-0-only operation behaves like a direct LUT read with one register stage.

Decomposition:
- Shared package const_lut_pkg:
  - Localparams LUT_IDX_W=3 and LUT_DATA_W=8.
  - A typedef for the LUT index and one for the LUT data.
  - A function onehot_rr(req, last) returning the round-robin one-hot grant.
- One natural sub-module: rr_grant. It is the combinational round-robin picker over NUM_REQ with inputs req, last_grant, en and output one-hot gnt. It is reusable by future shared-resource arbiters.
- Response register, pointer register and counter stay in the top module.

Test Plan:
- Reset, then requester 0 alone with idx 1 for one cycle -> req_ready=01, lut_idx=1; next cycle rsp_valid=01, rsp_data=8'd8, rsp_idx=1; following cycle rsp_valid=00.
- Both requesters continuously valid (r0 idx 3, r1 idx 5) for 4 cycles from reset -> grants alternate 01,10,01,10; responses 0xff, 65, 0xff, 65 one cycle later; conflict_cnt=4.
- r1 alone continuously with idx 0 -> granted every cycle; rsp_data=0x1f each cycle with rsp_valid=10.
- arb_en dropped the cycle after an r0 grant (idx 2) -> response 25 still delivered; req_ready=00 while arb_en=0; after re-enable with both valid, r1 is granted first.
- Drive 300 consecutive both-valid cycles -> conflict_cnt saturates at 255 and holds.
- rst_n pulsed low in the cycle after a grant -> rsp_valid drops immediately. No response appears after release. The next simultaneous request grants r0 first.
